// File: rtl/wb_queue.sv
// Write-back queue: FIFO of pending (rd, data) register-file writes, drained one per cycle.
// Optional read bypass (hit/fwd per read port) is compiled in when WB_BYPASS_EN is defined.
module wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic        drain_en,
  output logic        regwr,
  output logic [4:0]  rd,
  output logic [31:0] data,
  input  logic [4:0]  ra,
  input  logic [4:0]  rb,
  output logic        hit_a,
  output logic        hit_b,
  output logic [31:0] fwd_a,
  output logic [31:0] fwd_b,
  output logic        empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    r_mem_rd   [DEPTH];
  logic [31:0]   r_mem_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic w_accept;
  logic w_push;
  logic w_pop;

  assign in_ready = (r_count < CW'(DEPTH));
  assign empty    = (r_count == '0);
  assign w_accept = in_valid && in_ready;
  // Writes to r0 are architecturally meaningless, so they are accepted but never stored.
  assign w_push   = w_accept && (in_rd != 5'd0);
  assign w_pop    = (r_count != '0) && drain_en;

  assign regwr = w_pop;
  assign rd    = w_pop ? r_mem_rd[r_head]   : 5'd0;
  assign data  = w_pop ? r_mem_data[r_head] : 32'd0;

  // NOTE: the entry storage has no reset; r_count alone decides which slots are live,
  // so stale contents are never observable and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_rd[r_tail]   <= in_rd;
      r_mem_data[r_tail] <= in_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef WB_BYPASS_EN
  // Scan oldest to youngest so the last match wins; the head stays visible while it is written.
  always_comb begin
    hit_a = 1'b0;
    hit_b = 1'b0;
    fwd_a = 32'd0;
    fwd_b = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < r_count) begin
        if ((ra != 5'd0) && (r_mem_rd[r_head + PW'(i)] == ra)) begin
          hit_a = 1'b1;
          fwd_a = r_mem_data[r_head + PW'(i)];
        end
        if ((rb != 5'd0) && (r_mem_rd[r_head + PW'(i)] == rb)) begin
          hit_b = 1'b1;
          fwd_b = r_mem_data[r_head + PW'(i)];
        end
      end
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{ra, rb};
  assign hit_a = 1'b0;
  assign hit_b = 1'b0;
  assign fwd_a = 32'd0;
  assign fwd_b = 32'd0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed vector table plus hand-written
// sequences for steady-state wrap and reset during pending writes.
module tb_wb_queue;

`ifdef WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [4:0]  in_rd;
  logic [31:0] in_data;
  logic        in_ready;
  logic        drain_en;
  logic        regwr;
  logic [4:0]  rd;
  logic [31:0] data;
  logic [4:0]  ra, rb;
  logic        hit_a, hit_b;
  logic [31:0] fwd_a, fwd_b;
  logic        empty;

  int n_checks = 0;
  int n_errors = 0;

  wb_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_rd(in_rd), .in_data(in_data), .in_ready(in_ready),
    .drain_en(drain_en), .regwr(regwr), .rd(rd), .data(data),
    .ra(ra), .rb(rb), .hit_a(hit_a), .hit_b(hit_b), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  ird;
    logic [31:0] idata;
    logic        dr;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic        e_rdy;
    logic        e_wr;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
    logic        e_empty;
    logic        e_ha;
    logic [31:0] e_fa;
    logic        e_hb;
    logic [31:0] e_fb;
  } vec_t;

  function automatic vec_t mk(logic v, logic [4:0] ird, logic [31:0] idata, logic dr,
                              logic [4:0] a, logic [4:0] b, logic e_rdy, logic e_wr,
                              logic [4:0] e_rd, logic [31:0] e_data, logic e_empty,
                              logic e_ha, logic [31:0] e_fa, logic e_hb, logic [31:0] e_fb);
    vec_t t;
    t.v = v; t.ird = ird; t.idata = idata; t.dr = dr; t.ra = a; t.rb = b;
    t.e_rdy = e_rdy; t.e_wr = e_wr; t.e_rd = e_rd; t.e_data = e_data; t.e_empty = e_empty;
    t.e_ha = e_ha; t.e_fa = e_fa; t.e_hb = e_hb; t.e_fb = e_fb;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic [4:0] ird,
                       input logic [31:0] idata, input logic dr,
                       input logic [4:0] a, input logic [4:0] b);
    @(negedge clk);
    rst = r; in_valid = v; in_rd = ird; in_data = idata; drain_en = dr; ra = a; rb = b;
    #1;
  endtask

  vec_t vecs[21];
  logic [36:0] model[$];
  logic [36:0] head_e;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0; drain_en = 1'b0; ra = '0; rb = '0;
    //              v  ird   idata         dr ra rb  rdy wr rd  data          emp ha fa     hb fb
    vecs[0]  = mk(1, 5, 32'hDEADBEEF, 1, 0, 0,  1, 0, 0, 32'h0,        1, 0, 32'h0, 0, 32'h0);
    vecs[1]  = mk(0, 0, 32'h0,        1, 5, 0,  1, 1, 5, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0, 32'h0);
    vecs[2]  = mk(0, 0, 32'h0,        1, 0, 0,  1, 0, 0, 32'h0,        1, 0, 32'h0, 0, 32'h0);
    vecs[3]  = mk(1, 0, 32'h55,       1, 0, 0,  1, 0, 0, 32'h0,        1, 0, 32'h0, 0, 32'h0);
    vecs[4]  = mk(0, 0, 32'h0,        1, 0, 0,  1, 0, 0, 32'h0,        1, 0, 32'h0, 0, 32'h0);
    vecs[5]  = mk(1, 1, 32'h11,       0, 0, 0,  1, 0, 0, 32'h0,        1, 0, 32'h0, 0, 32'h0);
    vecs[6]  = mk(1, 2, 32'h22,       0, 0, 0,  1, 0, 0, 32'h0,        0, 0, 32'h0, 0, 32'h0);
    vecs[7]  = mk(1, 3, 32'h33,       0, 0, 0,  1, 0, 0, 32'h0,        0, 0, 32'h0, 0, 32'h0);
    vecs[8]  = mk(1, 4, 32'h44,       0, 0, 0,  1, 0, 0, 32'h0,        0, 0, 32'h0, 0, 32'h0);
    vecs[9]  = mk(1, 6, 32'h66,       0, 0, 0,  0, 0, 0, 32'h0,        0, 0, 32'h0, 0, 32'h0);
    vecs[10] = mk(1, 9, 32'h99,       1, 0, 0,  0, 1, 1, 32'h11,       0, 0, 32'h0, 0, 32'h0);
    vecs[11] = mk(0, 0, 32'h0,        1, 0, 0,  1, 1, 2, 32'h22,       0, 0, 32'h0, 0, 32'h0);
    vecs[12] = mk(0, 0, 32'h0,        1, 0, 0,  1, 1, 3, 32'h33,       0, 0, 32'h0, 0, 32'h0);
    vecs[13] = mk(0, 0, 32'h0,        1, 0, 0,  1, 1, 4, 32'h44,       0, 0, 32'h0, 0, 32'h0);
    vecs[14] = mk(0, 0, 32'h0,        1, 0, 0,  1, 0, 0, 32'h0,        1, 0, 32'h0, 0, 32'h0);
    vecs[15] = mk(1, 7, 32'hA,        0, 0, 0,  1, 0, 0, 32'h0,        1, 0, 32'h0, 0, 32'h0);
    vecs[16] = mk(1, 7, 32'hB,        0, 7, 0,  1, 0, 0, 32'h0,        0, 1, 32'hA, 0, 32'h0);
    vecs[17] = mk(0, 0, 32'h0,        0, 7, 0,  1, 0, 0, 32'h0,        0, 1, 32'hB, 0, 32'h0);
    vecs[18] = mk(0, 0, 32'h0,        1, 0, 7,  1, 1, 7, 32'hA,        0, 0, 32'h0, 1, 32'hB);
    vecs[19] = mk(0, 0, 32'h0,        1, 0, 7,  1, 1, 7, 32'hB,        0, 0, 32'h0, 1, 32'hB);
    vecs[20] = mk(0, 0, 32'h0,        1, 0, 0,  1, 0, 0, 32'h0,        1, 0, 32'h0, 0, 32'h0);

    drive(1, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 21; i++) begin
      drive(0, vecs[i].v, vecs[i].ird, vecs[i].idata, vecs[i].dr, vecs[i].ra, vecs[i].rb);
      check($sformatf("v%0d.in_ready", i), 32'(in_ready), 32'(vecs[i].e_rdy));
      check($sformatf("v%0d.regwr", i),    32'(regwr),    32'(vecs[i].e_wr));
      check($sformatf("v%0d.rd", i),       32'(rd),       32'(vecs[i].e_rd));
      check($sformatf("v%0d.data", i),     data,          vecs[i].e_data);
      check($sformatf("v%0d.empty", i),    32'(empty),    32'(vecs[i].e_empty));
      check($sformatf("v%0d.hit_a", i),    32'(hit_a),    BYP ? 32'(vecs[i].e_ha) : 32'd0);
      check($sformatf("v%0d.fwd_a", i),    fwd_a,         BYP ? vecs[i].e_fa : 32'd0);
      check($sformatf("v%0d.hit_b", i),    32'(hit_b),    BYP ? 32'(vecs[i].e_hb) : 32'd0);
      check($sformatf("v%0d.fwd_b", i),    fwd_b,         BYP ? vecs[i].e_fb : 32'd0);
    end

    // Steady state: three queued, then push and pop every cycle across several wraps.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 5'(i + 1), 32'h100 + 32'(i), 0, 0, 0);
      model.push_back({5'(i + 1), 32'h100 + 32'(i)});
    end
    for (int k = 0; k < 10; k++) begin
      drive(0, 1, 5'(4 + k), 32'h200 + 32'(k), 1, 0, 0);
      head_e = model.pop_front();
      check($sformatf("ss%0d.regwr", k),    32'(regwr),    32'd1);
      check($sformatf("ss%0d.rd", k),       32'(rd),       32'(head_e[36:32]));
      check($sformatf("ss%0d.data", k),     data,          head_e[31:0]);
      check($sformatf("ss%0d.in_ready", k), 32'(in_ready), 32'd1);
      model.push_back({5'(4 + k), 32'h200 + 32'(k)});
    end
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 0, 0, 1, 0, 0);
      head_e = model.pop_front();
      check($sformatf("tail%0d.regwr", k), 32'(regwr), 32'd1);
      check($sformatf("tail%0d.rd", k),    32'(rd),    32'(head_e[36:32]));
      check($sformatf("tail%0d.data", k),  data,       head_e[31:0]);
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    check("ss_end.empty", 32'(empty), 32'd1);
    check("ss_end.regwr", 32'(regwr), 32'd0);

    // Reset with two entries pending, while a push and a drain are also offered.
    drive(0, 1, 5'd10, 32'hA0, 0, 0, 0);
    drive(0, 1, 5'd11, 32'hB0, 0, 0, 0);
    drive(1, 1, 5'd12, 32'hC0, 1, 0, 0);
    drive(0, 0, 0, 0, 1, 5'd10, 5'd11);
    check("rst.empty",    32'(empty),    32'd1);
    check("rst.regwr",    32'(regwr),    32'd0);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.rd",       32'(rd),       32'd0);
    check("rst.data",     data,          32'd0);
    check("rst.hit_a",    32'(hit_a),    32'd0);
    check("rst.hit_b",    32'(hit_b),    32'd0);
    drive(0, 0, 0, 0, 1, 0, 0);
    check("rst2.empty",   32'(empty),    32'd1);
    check("rst2.regwr",   32'(regwr),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
